spu_stage_pipe: RTL
===================

# spu_stage_pipe

Per-pipe result staging chain for the dual-issue SPU. One instance per pipe (even, odd). Accepts issued instruction records from the RF/FU boundary, carries each as a packed 143-bit record through stages RFFU, 1..6 and a writeback stage, merges functional-unit results into the record at its completion stage, and drives the register-file write port. The packed stage outputs are the records the hazard unit and forwarding logic compare against.

## Interface
- `DEPTH`, 7: number of stages after RFFU; the last stage is writeback.
- `clk`  in  1  pipeline clock.
- `reset_n`  in  1  asynchronous, active-low reset. One clock domain.
- `stall`  in  1  hazard stall; RFFU loads a bubble instead of the issue record.
- `flush`  in  1  kills the records in RFFU and stage 1 (the shadow of a taken branch).
- `issue_valid`  in  1  issue record present this cycle.
- `issue_unit`  in  3  functional-unit id, placed in record bits [128:130].
- `issue_rt`  in  7  destination register, placed in bits [131:137].
- `issue_lat`  in  4  unit latency, 2..7, placed in bits [138:141].
- `issue_we`  in  1  register write enable, placed in bit [142].
- `res_valid`  in  1  a functional unit completes this cycle.
- `res_stage`  in  3  stage index (1..7) that the completing record enters this cycle.
- `res_data`  in  128  result, placed in bits [0:127].
- `packed_RFFUstage`, `packed_1stage` .. `packed_6stage`  out  143 each  stage records, MSB-first [0:142].
- `wb_en`  out  1  register-file write strobe.
- `wb_addr`  out  7  register-file write address.
- `wb_data`  out  128  register-file write data.
- `lat_err`  out  1  sticky: result targeted a bubble, or `res_stage` did not equal the record's latency.

## Operation
- Record layout: [0:127] result, [128:130] unit, [131:137] rt, [138:141] latency, [142] we. A bubble is all zeros (we=0).
- Each cycle every record moves one stage: RFFU → 1 → … → 6 → WB. The chain itself never stalls.
- RFFU load: issue record if `issue_valid && !stall && !flush`; otherwise a bubble. The result field of a newly loaded record is zero.
- Result merge: when `res_valid` is high, the record moving into stage `res_stage` takes `res_data` in [0:127]. Every other field is unchanged.
- `lat_err` sets when a merge targets a record with latency ≠ `res_stage`, or a bubble. It clears only on reset.
- Flush: the record moving into stage 1 becomes a bubble, and RFFU loads a bubble. Stages 2 and beyond are unaffected. Flush overrides issue and stall.
- Writeback: `wb_en` = WB.we; `wb_addr` = WB.rt; `wb_data` = WB.result.
- Because latency ≤ 7, every result is merged by the time its record reaches WB.

## Timing
- Reset (asynchronous assert, synchronous release): all stages are bubbles; `wb_en`=0, `wb_addr`=0, `wb_data`=0, `lat_err`=0.
- Issue at edge N appears on `packed_RFFUstage` after N. It reaches stage k after N+k. WB (`wb_en`) is valid after N+7.
- A merge with `res_stage`=k in the cycle before edge M is visible in `packed_kstage` after M.
- A merge and a flush both targeting stage 1 in the same cycle: the flush wins (bubble) and `lat_err` sets.
- Reset asserted mid-operation: all in-flight records are discarded, and no writeback happens for them.

## Configuration
- `SPU_STAGE_FWD_EN` defined: the block adds three source-address inputs `fwd_ra/rb/rc` (7 bits each) and outputs `fwd_*_hit` (1 bit) and `fwd_*_data` (128 bits).
  - The data comes from the youngest stage 1..WB whose record has we=1, rt = source, and stage index ≥ latency.
  - Output is combinational; with no hit, hit=0 and data=0.
- Not defined: these ports and the compare logic are absent.

## Structure
- Shared package `spu_pkg`:
  - record field bounds (RES, UNIT, RT, LAT, WE)
  - `REC_W`=143
  - bubble constant
  - unit-id encodings
- One sub-module, `spu_stage_reg`: a single stage register with reset, bubble-on-kill, and optional result merge. It is instantiated DEPTH+1 times.

## Test plan
- Issue rt=5, lat=2, we=1 at cycle 0; result 0xA5.. with `res_stage`=2 at cycle 1 → `packed_2stage`[0:127]=0xA5.. after cycle 2; `wb_en`=1, `wb_addr`=5 after cycle 7.
- Back-to-back issues rt=1..7 → `wb_addr` sequence 1..7 on consecutive cycles starting after cycle 7, with no gaps.
- `stall` with `issue_valid` for 2 cycles → two bubbles in RFFU; the corresponding WB cycles have `wb_en`=0.
- Records in RFFU, stage 1, and stage 2 when `flush` is pulsed → only the stage-2 record reaches writeback.
- Merge with `res_stage`=3 into a record with lat=5 → `lat_err`=1 and stays 1 until `reset_n` is asserted.
- With `SPU_STAGE_FWD_EN`: rt=9 lat=2 at stage 1 and rt=9 lat=2 at stage 4, `fwd_ra`=9 → hit from stage 4; one cycle later → hit from stage 2 (the younger record, now at its latency).

Source files
------------

// File: rtl/spu_stage_pipe_pkg.sv
// spu_pkg: shared definitions for the SPU per-pipe result staging chain.
//
// Record layout (MSB-first, index 0 is the MSB):
//   [0:127]   result
//   [128:130] functional-unit id
//   [131:137] destination register (rt)
//   [138:141] unit latency (2..7; 0 only in a bubble)
//   [142]     register write enable
// A bubble is the all-zero record.
//
// Optional feature macro used by the including design: SPU_STAGE_FWD_EN.
package spu_pkg;

    localparam int REC_W   = 143;

    localparam int RES_LO  = 0;
    localparam int RES_HI  = 127;
    localparam int UNIT_LO = 128;
    localparam int UNIT_HI = 130;
    localparam int RT_LO   = 131;
    localparam int RT_HI   = 137;
    localparam int LAT_LO  = 138;
    localparam int LAT_HI  = 141;
    localparam int WE_BIT  = 142;

    typedef logic [0:REC_W-1] rec_t;

    localparam rec_t BUBBLE = '0;

    typedef enum logic [2:0] {
        UNIT_NONE = 3'd0,
        UNIT_FX   = 3'd1,
        UNIT_BYTE = 3'd2,
        UNIT_PERM = 3'd3,
        UNIT_LS   = 3'd4,
        UNIT_SFP  = 3'd5,
        UNIT_BR   = 3'd6,
        UNIT_CH   = 3'd7
    } unit_e;

    // Build a freshly issued record; the result field starts at zero.
    function automatic rec_t pack_issue(input logic [2:0] unit,
                                        input logic [6:0] rt,
                                        input logic [3:0] lat,
                                        input logic       we);
        rec_t r;
        r                 = BUBBLE;
        r[UNIT_LO:UNIT_HI] = unit;
        r[RT_LO:RT_HI]     = rt;
        r[LAT_LO:LAT_HI]   = lat;
        r[WE_BIT]          = we;
        return r;
    endfunction

endpackage

// File: rtl/spu_stage_pipe_if.sv
// spu_stage_pipe_if: issue, result and writeback bundle of one SPU pipe.
//
// Handshake semantics: every group is valid-only with no ready/backpressure.
// A group is consumed on the clock edge where its valid (issue_valid,
// res_valid, wb_en) is high; the staging chain always advances, so the
// producer never waits and the consumer must accept every valid beat.
//
// Modports:
//   master - issue logic / functional units: drives issue_* and res_*,
//            observes wb_*.
//   slave  - the staging chain: observes issue_* and res_*, drives wb_*.
interface spu_stage_pipe_if;
    logic         issue_valid;
    logic [2:0]   issue_unit;
    logic [6:0]   issue_rt;
    logic [3:0]   issue_lat;
    logic         issue_we;

    logic         res_valid;
    logic [2:0]   res_stage;
    logic [127:0] res_data;

    logic         wb_en;
    logic [6:0]   wb_addr;
    logic [127:0] wb_data;

    modport master (
        output issue_valid, issue_unit, issue_rt, issue_lat, issue_we,
        output res_valid, res_stage, res_data,
        input  wb_en, wb_addr, wb_data
    );

    modport slave (
        input  issue_valid, issue_unit, issue_rt, issue_lat, issue_we,
        input  res_valid, res_stage, res_data,
        output wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/spu_stage_pipe_stage_reg.sv
// spu_stage_reg: one record register of the staging chain.
//
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset (loads a bubble)
//   kill          - load a bubble instead of d_rec
//   merge         - replace the result field of d_rec with merge_data
//   merge_data    - 128-bit functional-unit result
//   d_rec         - record arriving from the previous stage
//   q_rec         - registered record of this stage
module spu_stage_reg
    import spu_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         kill,
    input  logic         merge,
    input  logic [127:0] merge_data,
    input  rec_t         d_rec,
    output rec_t         q_rec
);

    rec_t rec_d;
    rec_t rec_q;

    // Kill is applied last so a killed record stays a bubble even when a
    // result was aimed at it in the same cycle.
    always_comb begin
        rec_d = d_rec;
        if (merge) begin
            rec_d[RES_LO:RES_HI] = merge_data;
        end
        if (kill) begin
            rec_d = BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rec_q <= BUBBLE;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign q_rec = rec_q;

endmodule

// File: rtl/spu_stage_pipe.sv
// spu_stage_pipe: per-pipe result staging chain (RFFU, stages 1..6, WB).
//
// Every cycle each record advances one stage; the chain never stalls.
// Functional-unit results are merged into the record entering res_stage,
// and the WB stage drives the register-file write port.
//
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   stall                 - RFFU loads a bubble instead of the issue record
//   flush                 - kills the records in RFFU and stage 1
//   bus (slave)           - issue_*, res_* in; wb_en/wb_addr/wb_data out
//   packed_RFFUstage,
//   packed_1stage..6stage - stage records for hazard/forwarding compare
//   lat_err               - sticky: misdirected or mistimed result
//   fwd_ra/rb/rc, fwd_*_hit, fwd_*_data
//                         - forwarding lookup, present only when the
//                           macro SPU_STAGE_FWD_EN is defined
//
// DEPTH counts the stages after RFFU, the last being WB; the packed stage
// outputs assume the default of 7.
module spu_stage_pipe
    import spu_pkg::*;
#(
    parameter int DEPTH = 7
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         stall,
    input  logic         flush,
    spu_stage_pipe_if.slave bus,
    output rec_t         packed_RFFUstage,
    output rec_t         packed_1stage,
    output rec_t         packed_2stage,
    output rec_t         packed_3stage,
    output rec_t         packed_4stage,
    output rec_t         packed_5stage,
    output rec_t         packed_6stage,
`ifdef SPU_STAGE_FWD_EN
    input  logic [6:0]   fwd_ra,
    input  logic [6:0]   fwd_rb,
    input  logic [6:0]   fwd_rc,
    output logic         fwd_ra_hit,
    output logic         fwd_rb_hit,
    output logic         fwd_rc_hit,
    output logic [127:0] fwd_ra_data,
    output logic [127:0] fwd_rb_data,
    output logic [127:0] fwd_rc_data,
`endif
    output logic         lat_err
);

    rec_t           stage_in [0:DEPTH];
    rec_t           stage_q  [0:DEPTH];
    logic [DEPTH:0] stage_kill;
    logic [DEPTH:0] stage_merge;
    logic [3:0]     tgt_lat;
    logic           lat_err_d;
    logic           lat_err_q;

    // Stage inputs and kill/merge controls. Flush kills the record moving
    // into stage 1 (from RFFU), the one leaving stage 1 (into stage 2) and
    // the new RFFU load; the record already in stage 2 proceeds.
    always_comb begin
        stage_in[0]    = pack_issue(bus.issue_unit, bus.issue_rt,
                                    bus.issue_lat, bus.issue_we);
        stage_kill[0]  = !bus.issue_valid || stall || flush;
        stage_merge[0] = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            stage_in[k]    = stage_q[k-1];
            stage_kill[k]  = flush && (k <= 2);
            stage_merge[k] = bus.res_valid && (bus.res_stage == 3'(k));
        end
    end

    for (genvar g = 0; g <= DEPTH; g++) begin : g_stage
        spu_stage_reg u_stage (
            .clk        (clk),
            .reset_n    (reset_n),
            .kill       (stage_kill[g]),
            .merge      (stage_merge[g]),
            .merge_data (bus.res_data),
            .d_rec      (stage_in[g]),
            .q_rec      (stage_q[g])
        );
    end

    // Latency seen by the target record after any kill; a killed or empty
    // slot reads as 0, which never matches a legal res_stage.
    always_comb begin
        tgt_lat = 4'd0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (bus.res_stage == 3'(k)) begin
                tgt_lat = stage_kill[k] ? 4'd0 : stage_q[k-1][LAT_LO:LAT_HI];
            end
        end
        lat_err_d = lat_err_q;
        if (bus.res_valid &&
            ((bus.res_stage == 3'd0) || (tgt_lat != {1'b0, bus.res_stage}))) begin
            lat_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_err_q <= 1'b0;
        end else begin
            lat_err_q <= lat_err_d;
        end
    end

    assign lat_err = lat_err_q;

    assign bus.wb_en   = stage_q[DEPTH][WE_BIT];
    assign bus.wb_addr = stage_q[DEPTH][RT_LO:RT_HI];
    assign bus.wb_data = stage_q[DEPTH][RES_LO:RES_HI];

    assign packed_RFFUstage = stage_q[0];
    assign packed_1stage    = stage_q[1];
    assign packed_2stage    = stage_q[2];
    assign packed_3stage    = stage_q[3];
    assign packed_4stage    = stage_q[4];
    assign packed_5stage    = stage_q[5];
    assign packed_6stage    = stage_q[6];

    // WB unit/latency fields have no consumer once the record retires.
    logic unused_wb_fields;
    assign unused_wb_fields = ^{stage_q[DEPTH][UNIT_LO:UNIT_HI],
                                stage_q[DEPTH][LAT_LO:LAT_HI]};

`ifdef SPU_STAGE_FWD_EN
    logic [6:0]   fwd_src  [0:2];
    logic [2:0]   fwd_hit;
    logic [127:0] fwd_data [0:2];

    // Scan oldest to youngest so the youngest eligible stage wins. A
    // record is only eligible once its result has been merged, i.e. its
    // stage index has reached its latency.
    always_comb begin
        fwd_src[0] = fwd_ra;
        fwd_src[1] = fwd_rb;
        fwd_src[2] = fwd_rc;
        for (int s = 0; s < 3; s++) begin
            fwd_hit[s]  = 1'b0;
            fwd_data[s] = '0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (stage_q[k][WE_BIT] &&
                    (stage_q[k][RT_LO:RT_HI] == fwd_src[s]) &&
                    (4'(k) >= stage_q[k][LAT_LO:LAT_HI])) begin
                    fwd_hit[s]  = 1'b1;
                    fwd_data[s] = stage_q[k][RES_LO:RES_HI];
                end
            end
        end
    end

    assign fwd_ra_hit  = fwd_hit[0];
    assign fwd_rb_hit  = fwd_hit[1];
    assign fwd_rc_hit  = fwd_hit[2];
    assign fwd_ra_data = fwd_data[0];
    assign fwd_rb_data = fwd_data[1];
    assign fwd_rc_data = fwd_data[2];
`endif

endmodule
